sram_req_arbiter: RTL

- Merges the CPU core's inst and data SRAM-like request ports into one SRAM-like master port feeding the AXI transfer bridge.
- Priority arbitration: data over inst, with grant lock while a request is pending.
- In-order outstanding-transaction FIFO routes each master data_ok/rdata back to the port that issued it.
- Lets the core run concurrent fetch and load/store over a single-ported bridge.

---
 rtl/sram_req_arbiter_if.sv | 27 ++
 rtl/sram_req_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response port: request + command out, accept/complete back.
// One instance per inst, data and merged master port.
interface sram_req_arbiter_if #(
    parameter int CMD_W = 71
);
    logic             req;
    logic [CMD_W-1:0] cmd;
    logic             addr_ok;
    logic             data_ok;
    logic [31:0]      rdata;

    modport master (
        output req,
        output cmd,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  cmd,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Merges inst and data SRAM-like ports onto one master port; data has priority,
// a stalled grant is locked, and an in-order FIFO routes completions back.
module sram_req_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int CMD_W       = 71
) (
    input  logic              clk,
    input  logic              reset,
    sram_req_arbiter_if.slave  inst,
    sram_req_arbiter_if.slave  data,
    sram_req_arbiter_if.master m
);
    localparam int PW = $clog2(OUTST_DEPTH);
    localparam int CW = PW + 1;

    logic [OUTST_DEPTH-1:0] src_q;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   lock_vld;
    logic                   lock_src;

    logic sel;
    logic can_issue;
    logic req;
    logic push;
    logic pop;
    logic head;

    always_comb begin
        sel       = lock_vld ? lock_src : data.req;
        can_issue = (count != CW'(OUTST_DEPTH));
        req       = ~reset & can_issue & (sel ? data.req : inst.req);
        push      = req & m.addr_ok;
        pop       = ~reset & m.data_ok & (count != '0);
        head      = src_q[rd_ptr];
    end

    assign m.req        = req;
    assign m.cmd        = reset ? '0 : (sel ? data.cmd : inst.cmd);
    assign inst.addr_ok = push & ~sel;
    assign data.addr_ok = push & sel;
    assign inst.data_ok = pop & ~head;
    assign data.data_ok = pop & head;
    assign inst.rdata   = reset ? '0 : m.rdata;
    assign data.rdata   = reset ? '0 : m.rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lock_vld <= 1'b0;
            lock_src <= 1'b0;
        end else begin
            if (push) begin
                src_q[wr_ptr] <= sel;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Hold the stalled source so the bridge sees a stable command.
            if (req && !m.addr_ok) begin
                lock_vld <= 1'b1;
                lock_src <= sel;
            end else if (push) begin
                lock_vld <= 1'b0;
            end
        end
    end
endmodule
